// File: rtl/matinv_pkg.sv
// matinv_pkg: definitions shared by matinv_ctrl and the matinv<N> inverters.
//   state_t          controller FSM states (IDLE, LOAD, SETTLE, UNLOAD)
//   MATINV_MAX_SIZE  largest supported matrix dimension
//   matinv_idx_w(n)  width of an element index for an n x n matrix
//   mat_t            working matrix of 64-bit words
//   matinv_adj_elem  one element of the adjugate matrix
//
// The inverters use integer arithmetic modulo 2^64 and keep the low DATA_WIDTH
// bits of each result. Only +, - and * are used, so the low bits do not depend
// on whether the elements are read as signed or unsigned. DATA_WIDTH <= 64.
package matinv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, UNLOAD} state_t;

  localparam int MATINV_MAX_SIZE = 4;

  typedef logic [63:0] mat_t [MATINV_MAX_SIZE][MATINV_MAX_SIZE];

  function automatic int matinv_idx_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  // Determinant of the leading k x k block of a, for k = 1..3.
  function automatic logic [63:0] det_k(input int k, input mat_t a);
    case (k)
      1:       return a[0][0];
      2:       return a[0][0] * a[1][1] - a[0][1] * a[1][0];
      default: return a[0][0] * (a[1][1] * a[2][2] - a[1][2] * a[2][1])
                    - a[0][1] * (a[1][0] * a[2][2] - a[1][2] * a[2][0])
                    + a[0][2] * (a[1][0] * a[2][1] - a[1][1] * a[2][0]);
    endcase
  endfunction

  // adj[i][j] = (-1)^(i+j) * det(m without row j and column i).
  function automatic logic [63:0] matinv_adj_elem(input int n, input mat_t m,
                                                  input int i, input int j);
    mat_t        sub;
    logic [63:0] d;
    sub = '{default: '0};
    for (int r = 0; r < MATINV_MAX_SIZE - 1; r++)
      for (int c = 0; c < MATINV_MAX_SIZE - 1; c++)
        sub[r][c] = m[(r >= j) ? r + 1 : r][(c >= i) ? c + 1 : c];
    d = det_k(n - 1, sub);
    return (((i + j) % 2) != 0) ? -d : d;
  endfunction

endpackage

// File: rtl/matinv_ctrl_inv.sv
// matinv2 / matinv3 / matinv4: combinational integer inverters.
// Each one returns the adjugate of the input matrix. This is the inverse scaled
// by the determinant, so it is the exact inverse when det = 1. Results are
// truncated to DATA_WIDTH bits. There is no overflow detection.
// Ports (N = 2, 3 or 4; element i = row*N+col at [i*DATA_WIDTH +: DATA_WIDTH]):
//   i_mat  in   N*N*DATA_WIDTH  flattened operand matrix
//   o_inv  out  N*N*DATA_WIDTH  flattened adjugate matrix
module matinv2
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [4*DATA_WIDTH-1:0] i_mat,
  output logic [4*DATA_WIDTH-1:0] o_inv
);
  localparam int N = 2;
  mat_t w_m;

  always_comb begin
    // NOTE: every variable is given a default first, so no path can leave one
    // unassigned and infer a latch.
    w_m   = '{default: '0};
    o_inv = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = 64'(i_mat[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        o_inv[(r*N+c)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(matinv_adj_elem(N, w_m, r, c));
  end
endmodule

module matinv3
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [9*DATA_WIDTH-1:0] i_mat,
  output logic [9*DATA_WIDTH-1:0] o_inv
);
  localparam int N = 3;
  mat_t w_m;

  always_comb begin
    w_m   = '{default: '0};
    o_inv = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = 64'(i_mat[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        o_inv[(r*N+c)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(matinv_adj_elem(N, w_m, r, c));
  end
endmodule

module matinv4
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [16*DATA_WIDTH-1:0] i_mat,
  output logic [16*DATA_WIDTH-1:0] o_inv
);
  localparam int N = 4;
  mat_t w_m;

  always_comb begin
    w_m   = '{default: '0};
    o_inv = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w_m[r][c] = 64'(i_mat[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        o_inv[(r*N+c)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(matinv_adj_elem(N, w_m, r, c));
  end
endmodule

// File: rtl/matinv_ctrl.sv
// matinv_ctrl: sequencing controller for the combinational matinv<N> inverter.
// The controller loads N*N elements into the operand register, holds the
// operand for SETTLE_CYCLES cycles, and then captures the inverter output. It
// then streams the result out one element per cycle. Element order in both
// directions is index = row*N + col, in ascending order.
// Ports:
//   clk, rst (async, active-high)
//   in_valid / in_ready / in_data        input element stream
//   out_valid / out_ready / out_data     result element stream
//   out_last                             marks the final result element (N*N-1)
//   busy                                 high whenever the FSM is not IDLE
// Optional build macro MATINV_CTRL_FRAMING_EN adds the following ports:
//   in_last    in   expected high on the final input element
//   frame_err  out  sticky until rst; set when in_last disagrees with the count
module matinv_ctrl
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int MATRIX_SIZE   = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef MATINV_CTRL_FRAMING_EN
  input  logic                  in_last,
  output logic                  frame_err,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int NN    = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W = matinv_idx_w(MATRIX_SIZE);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                     r_state, w_next_state;
  logic [IDX_W-1:0]           r_idx;
  logic [SET_W-1:0]           r_settle;
  logic [NN*DATA_WIDTH-1:0]   r_operand, r_result, w_inv;
  logic                       w_in_hs, w_out_hs, w_idx_last, w_settle_done;

  assign w_in_hs       = in_valid && in_ready;
  assign w_out_hs      = out_valid && out_ready;
  assign w_idx_last    = (r_idx == IDX_LAST);
  assign w_settle_done = (r_settle == SET_LAST);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values
    // no matter how the statements are ordered.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // The next state is derived from in_valid/out_ready directly rather than
  // from the handshake wires, so that no loop runs through in_ready.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_idx_last) w_next_state = SETTLE;
      end
      SETTLE: if (w_settle_done) w_next_state = UNLOAD;
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && w_idx_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign out_last = out_valid && w_idx_last;
  assign out_data = out_valid ? r_result[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_settle  <= '0;
      // NOTE: these wide registers are plain flops rather than RAM, so they
      // take the async reset like the rest of the state.
      r_operand <= '0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        IDLE, LOAD: begin
          if (w_in_hs) begin
            r_operand[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
          end
          r_settle <= '0;
        end
        SETTLE: begin
          if (w_settle_done) begin
            r_result <= w_inv;
            r_settle <= '0;
            r_idx    <= '0;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        UNLOAD: if (w_out_hs) r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

`ifdef MATINV_CTRL_FRAMING_EN
  logic r_frame_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_frame_err <= 1'b0;
    else if (w_in_hs && (in_last != w_idx_last)) r_frame_err <= 1'b1;
  end
  assign frame_err = r_frame_err;
`endif

  generate
    if (MATRIX_SIZE == 2) begin : g_inv2
      matinv2 #(.DATA_WIDTH(DATA_WIDTH)) u_inv (.i_mat(r_operand), .o_inv(w_inv));
    end else if (MATRIX_SIZE == 3) begin : g_inv3
      matinv3 #(.DATA_WIDTH(DATA_WIDTH)) u_inv (.i_mat(r_operand), .o_inv(w_inv));
    end else begin : g_inv4
      matinv4 #(.DATA_WIDTH(DATA_WIDTH)) u_inv (.i_mat(r_operand), .o_inv(w_inv));
    end
  endgenerate

endmodule

// File: tb/tb_matinv_ctrl.sv
// tb_matinv_ctrl: randomized bench for matinv_ctrl (N=3, DATA_WIDTH=16).
// The reference model computes each 3x3 adjugate with the cyclic cofactor
// formula and keeps the low 16 bits. When MATINV_CTRL_FRAMING_EN is defined,
// the in_last/frame_err checks are added.
module tb_matinv_ctrl;
  localparam int W      = 16;
  localparam int N      = 3;
  localparam int NN     = N * N;
  localparam int SETTLE = 4;

  typedef logic [W-1:0] mat9_t [NN];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] in_data, out_data;
`ifdef MATINV_CTRL_FRAMING_EN
  logic         in_last, frame_err;
  int           last_at  = NN - 1;
  bit           exp_ferr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  matinv_ctrl #(.DATA_WIDTH(W), .MATRIX_SIZE(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef MATINV_CTRL_FRAMING_EN
    .in_last  (in_last),
    .frame_err(frame_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'(signed'(v));
  endfunction

  // adj[i][j] = cofactor(j,i). For a 3x3 matrix, cyclic row/column indexing
  // gives each cofactor with its sign already included.
  function automatic void model(input mat9_t m, output mat9_t r);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int r1 = (j + 1) % N, r2 = (j + 2) % N, c1 = (i + 1) % N, c2 = (i + 2) % N;
        r[i*N+j] = W'(sx(m[r1*N+c1]) * sx(m[r2*N+c2]) - sx(m[r1*N+c2]) * sx(m[r2*N+c1]));
      end
  endfunction

  function automatic void rand_mat(output mat9_t m);
    for (int i = 0; i < NN; i++) begin
      int v = int'($urandom_range(0, 18)) - 9;
      m[i] = W'(v);
    end
  endfunction

  // Sends one matrix. in_valid is held low for gap_len cycles before beat gap_at.
  task automatic send(input mat9_t m, input int gap_at, input int gap_len);
    for (int i = 0; i < NN; i++) begin
      int w = 0;
      if (i == gap_at) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          step();
          check("gap_busy", busy, 1);
          check("gap_in_ready", in_ready, 1);
        end
      end
      in_valid = 1'b1;
      in_data  = m[i];
`ifdef MATINV_CTRL_FRAMING_EN
      in_last  = (i == last_at);
      if ((i == last_at) != (i == NN - 1)) exp_ferr = 1'b1;
`endif
      while (!in_ready && w < 100) begin step(); w++; end
      check("in_ready_load", in_ready, 1);
      step();
`ifdef MATINV_CTRL_FRAMING_EN
      check("frame_err", frame_err, exp_ferr);
`endif
    end
    in_valid = 1'b0;
    in_data  = '0;
`ifdef MATINV_CTRL_FRAMING_EN
    in_last  = 1'b0;
`endif
  endtask

  // Must be called immediately after send(). The first out_valid is expected
  // SETTLE cycles after returning. bp toggles out_ready every cycle. junk
  // drives in_valid, which the controller must ignore.
  task automatic receive(input mat9_t exp, input bit bp, input bit junk);
    int k = 0;
    int w = 0;
    in_valid = junk;
    in_data  = W'($urandom);
    while (!out_valid && w < 200) begin step(); w++; end
    check("latency", w, SETTLE);
    w = 0;
    while (k < NN && w < 400) begin
      out_ready = bp ? !out_ready : 1'b1;
      in_data   = W'($urandom);
      check("out_valid", out_valid, 1);
      check("in_ready_unload", in_ready, 0);
      check("busy_unload", busy, 1);
      check("out_data", out_data, exp[k]);
      check("out_last", out_last, (k == NN - 1));
      if (out_ready) k++;
      step();
      w++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("beat_count", k, NN);
    check("in_ready_idle", in_ready, 1);
    check("busy_idle", busy, 0);
    check("out_valid_idle", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mat9_t m, exp;
    int    w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef MATINV_CTRL_FRAMING_EN
    in_last = 1'b0;
`endif
    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
`ifdef MATINV_CTRL_FRAMING_EN
    check("rst_frame_err", frame_err, 0);
`endif
    rst = 1'b0;
    step();

    // Identity in, identity out.
    for (int i = 0; i < NN; i++) m[i] = (i % (N + 1) == 0) ? W'(1) : W'(0);
    send(m, -1, 0);
    receive(m, 1'b0, 1'b0);

    // The same matrix with and without an input gap between beats 4 and 5.
    rand_mat(m);
    model(m, exp);
    send(m, -1, 0);
    receive(exp, 1'b0, 1'b0);
    send(m, 4, 5);
    receive(exp, 1'b0, 1'b0);

    // Output backpressure, with in_valid driven during SETTLE/UNLOAD.
    rand_mat(m);
    model(m, exp);
    send(m, -1, 0);
    receive(exp, 1'b1, 1'b1);

    // Reset in UNLOAD after three outputs.
    rand_mat(m);
    model(m, exp);
    send(m, -1, 0);
    w = 0;
    while (!out_valid && w < 100) begin step(); w++; end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("pre_rst_data", out_data, exp[k]);
      step();
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    rand_mat(m);
    model(m, exp);
    send(m, -1, 0);
    receive(exp, 1'b0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 100; f++) begin
      rand_mat(m);
      model(m, exp);
      send(m, int'($urandom_range(1, NN - 1)), int'($urandom_range(0, 3)));
      receive(exp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MATINV_CTRL_FRAMING_EN
    // in_last on beat 5: frame_err is set and the remaining beats still load.
    last_at = 4;
    rand_mat(m);
    model(m, exp);
    send(m, -1, 0);
    receive(exp, 1'b0, 1'b0);
    check("frame_err_sticky", frame_err, 1);
    last_at = NN - 1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
